// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbitration slice.
//   XLEN     : operand/result width.
//   SHAMT_W  : shift amount width.
//   shift_dir_e : direction encoding carried on req_dir/shf_dir.
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, reusable for any shared execution resource.
// Ports:
//   req       in  N      request vector
//   ptr       in  PTR_W  highest-priority index for this cycle
//   enable    in  1      grant permitted this cycle
//   grant     out N      one-hot grant (all-zero when disabled or idle)
//   grant_idx out PTR_W  index of the winner; equals ptr when nothing is granted
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] base,
                                            input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    return PTR_W'(sum % N);
  endfunction

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    idx       = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      idx = wrap(ptr, i);
      if (enable && !found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one external combinational barrel shifter between NUM_REQ requesters.
// One command is granted per cycle (round-robin), its fields are driven onto
// shf_*, and shf_out is captured into a one-entry response register.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         per-requester command handshake
//   req_data/amt/dir/arith      packed per-requester command fields
//   shf_in/n/dir/arith, shf_out shifter drive and its combinational result
//   resp_valid/ready/data/id    response handshake with requester index
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*XLEN-1:0]    req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_amt,
  input  logic [NUM_REQ-1:0]         req_dir,
  input  logic [NUM_REQ-1:0]         req_arith,
  output logic [XLEN-1:0]            shf_in,
  output logic [SHAMT_W-1:0]         shf_n,
  output logic                       shf_dir,
  output logic                       shf_arith,
  input  logic [XLEN-1:0]            shf_out,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [XLEN-1:0]            resp_data,
  output logic [ID_W-1:0]            resp_id
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic               slot_free;
  logic               accept;
  logic [XLEN-1:0]    data_arr [NUM_REQ];
  logic [SHAMT_W-1:0] amt_arr  [NUM_REQ];

  // A draining register can take a new result in the same cycle.
  assign slot_free = !resp_valid || resp_ready;

  // Gating with rst_n keeps req_ready low for the whole reset interval,
  // not just after the first edge.
  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (slot_free && rst_n),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign accept = |req_ready;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*XLEN +: XLEN];
      amt_arr[i]  = req_amt[i*SHAMT_W +: SHAMT_W];
    end
  end

  // grant_idx falls back to ptr when idle, so the shifter inputs stay defined.
  assign shf_in    = data_arr[grant_idx];
  assign shf_n     = amt_arr[grant_idx];
  assign shf_dir   = req_dir[grant_idx];
  assign shf_arith = req_arith[grant_idx];

  assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      ptr        <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data  <= shf_out;
      resp_id    <= ID_W'(grant_idx);
      ptr        <= ptr_next;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data;
  logic [9:0]  req_amt;
  logic [1:0]  req_dir;
  logic [1:0]  req_arith;
  logic [31:0] shf_in;
  logic [4:0]  shf_n;
  logic        shf_dir;
  logic        shf_arith;
  logic [31:0] shf_out;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [0:0]  resp_id;

  shift_arbiter #(
    .NUM_REQ (2),
    .ID_W    (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_dir    (req_dir),
    .req_arith  (req_arith),
    .shf_in     (shf_in),
    .shf_n      (shf_n),
    .shf_dir    (shf_dir),
    .shf_arith  (shf_arith),
    .shf_out    (shf_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment barrel shifter.
  logic signed [31:0] sra_res;
  assign sra_res = $signed(shf_in) >>> shf_n;
  always_comb begin
    if (!shf_dir)      shf_out = shf_in << shf_n;
    else if (shf_arith) shf_out = sra_res;
    else               shf_out = shf_in >> shf_n;
  end

  typedef struct packed {
    logic [31:0] data;
    logic [0:0]  id;
  } resp_t;

  resp_t       sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ptr_m = 0;
  logic [1:0]  acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_shift(input logic [31:0] d, input logic [4:0] n,
                                            input logic dir, input logic ar);
    logic [31:0] r;
    if (!dir) begin
      r = d << n;
    end else begin
      r = d >> n;
      if (ar && d[31]) r = r | ~(32'hFFFF_FFFF >> n);
    end
    return r;
  endfunction

  task automatic set_cmd(input int i, input logic [31:0] d, input logic [4:0] n,
                         input logic dir, input logic ar);
    req_data[i*32 +: 32] = d;
    req_amt[i*5 +: 5]    = n;
    req_dir[i]           = dir;
    req_arith[i]         = ar;
    req_valid[i]         = 1'b1;
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    int         g;
    logic [1:0] exp_ready;
    resp_t      e;
    #4;
    g = -1;
    exp_ready = 2'b00;
    acc = 2'b00;
    if (sb_q.size() == 0 || resp_ready) begin
      for (int k = 0; k < 2; k++) begin
        if (g < 0 && req_valid[(ptr_m + k) % 2]) g = (ptr_m + k) % 2;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (sb_q.size() > 0 && resp_ready) void'(sb_q.pop_front());
    if (g >= 0) begin
      e.data = exp_shift(req_data[g*32 +: 32], req_amt[g*5 +: 5], req_dir[g], req_arith[g]);
      e.id   = 1'(g);
      sb_q.push_back(e);
      ptr_m  = (g + 1) % 2;
      acc[g] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_data", resp_data, sb_q[0].data);
      check("resp_id", 32'(resp_id), 32'(sb_q[0].id));
    end else begin
      check("resp_valid_idle", 32'(resp_valid), 32'd0);
    end
  endtask

  task automatic single0(input logic [31:0] d, input logic [4:0] n,
                         input logic dir, input logic ar);
    set_cmd(0, d, n, dir, ar);
    cycle();
    req_valid = 2'b00;
  endtask

  task automatic refill();
    for (int i = 0; i < 2; i++)
      if (acc[i]) set_cmd(i, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_data   = '0;
    req_amt    = '0;
    req_dir    = '0;
    req_arith  = '0;
    resp_ready = 1'b1;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester, fixed vectors.
    single0(32'h0000_00F0, 5'd4, 1'b0, 1'b0);
    check("vec_shl", resp_data, 32'h0000_0F00);
    single0(32'h8000_0000, 5'd31, 1'b1, 1'b1);
    check("vec_sra", resp_data, 32'hFFFF_FFFF);
    single0(32'h8000_0000, 5'd31, 1'b1, 1'b0);
    check("vec_srl", resp_data, 32'h0000_0001);
    single0(32'h1234_5678, 5'd0, 1'b1, 1'b1);
    check("vec_zero_amt", resp_data, 32'h1234_5678);
    cycle();  // drain, register empties

    // Both valid, full throughput; model ptr enforces alternation.
    set_cmd(0, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    set_cmd(1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    for (int c = 0; c < 8; c++) begin
      cycle();
      refill();
    end

    // Back-pressure for 3 cycles, then release.
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      refill();
    end
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      refill();
    end
    req_valid = 2'b00;
    cycle();

    // Reset mid-stream with ptr pointing at requester 1.
    if (ptr_m != 0) begin
      set_cmd(1, 32'h0000_0001, 5'd1, 1'b0, 1'b0);
      cycle();
      req_valid = 2'b00;
    end
    single0(32'hA5A5_0000, 5'd8, 1'b1, 1'b0);
    resp_ready = 1'b0;
    req_valid  = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    sb_q.delete();
    ptr_m = 0;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    cycle();
    check("post_rst_first_id", 32'(resp_id), 32'd0);
    req_valid = 2'b00;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
